// File: rtl/bus_pkg.sv
// bus_pkg: shared defaults and driver-enable helpers for the bus receiver
package bus_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NDRV  = 4;
  localparam int DEF_DEPTH = 4;
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction
  function automatic int onehot_idx(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/bus_rx_fifo.sv
// bus_rx_fifo: show-ahead FIFO (i_push/i_data in, i_pop/o_data out, o_full/o_empty/o_count status); push while full succeeds only with a pop
module bus_rx_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_we, w_re;
  assign o_count = r_count;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_re    = i_pop & ~o_empty;
  assign w_we    = i_push & (~o_full | w_re);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_re) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_we) - CW'(w_re);
    end
  end
endmodule

// File: rtl/bus_rx.sv
// bus_rx: tri-state bus receiver; captures bus_in when ld and exactly one drv_en bit are set, queues it in a show-ahead FIFO (out_data/out_valid/out_ready, full/empty/count) and raises sticky err_float/err_contend/err_ovf until clr_err; BUS_RX_SRC_TAG_EN adds out_src, the capturing driver index
module bus_rx
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDRV  = DEF_NDRV,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            bus_in,
  input  logic [NDRV-1:0]             drv_en,
  input  logic                        ld,
  input  logic                        clr_err,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
`ifdef BUS_RX_SRC_TAG_EN
  output logic [$clog2(NDRV)-1:0]     out_src,
`endif
  output logic                        err_float,
  output logic                        err_contend,
  output logic                        err_ovf
);
`ifdef BUS_RX_SRC_TAG_EN
  localparam int SW = $clog2(NDRV);
  localparam int DW = WIDTH + SW;
`else
  localparam int DW = WIDTH;
`endif
  logic          w_onehot, w_push, w_pop, w_float, w_contend, w_ovf;
  logic [DW-1:0] w_wdata, w_rdata;
  logic          r_err_float, r_err_contend, r_err_ovf;
  assign w_onehot  = is_onehot(32'(drv_en));
  assign w_push    = ld & w_onehot;
  assign w_pop     = out_valid & out_ready;
  assign w_float   = ld & ~|drv_en;
  assign w_contend = ld & |drv_en & ~w_onehot;
  assign w_ovf     = w_push & full & ~w_pop;
  assign out_valid = ~empty;
`ifdef BUS_RX_SRC_TAG_EN
  assign w_wdata  = {SW'(onehot_idx(32'(drv_en))), bus_in};
  assign out_data = w_rdata[WIDTH-1:0];
  assign out_src  = w_rdata[DW-1:WIDTH];
`else
  assign w_wdata  = bus_in;
  assign out_data = w_rdata;
`endif
  bus_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_data  (w_rdata),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );
  // a new error event on the same edge as clr_err keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_float   <= 1'b0;
      r_err_contend <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_err_float   <= w_float   | (r_err_float   & ~clr_err);
      r_err_contend <= w_contend | (r_err_contend & ~clr_err);
      r_err_ovf     <= w_ovf     | (r_err_ovf     & ~clr_err);
    end
  end
  assign err_float   = r_err_float;
  assign err_contend = r_err_contend;
  assign err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_bus_rx.sv
// tb_bus_rx: directed vector table, reset corner cases and a randomized queue-model run for bus_rx
module tb_bus_rx;
  logic        clk = 0, rst = 1;
  logic [31:0] bus_in = 0;
  logic [3:0]  drv_en = 0;
  logic        ld = 0, clr_err = 0, out_ready = 0;
  logic [31:0] out_data;
  logic        out_valid, full, empty, err_float, err_contend, err_ovf;
  logic [2:0]  count;
`ifdef BUS_RX_SRC_TAG_EN
  logic [1:0]  out_src;
`endif
  int errors = 0, checks = 0;

  bus_rx dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .drv_en(drv_en), .ld(ld), .clr_err(clr_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .count(count),
`ifdef BUS_RX_SRC_TAG_EN
    .out_src(out_src),
`endif
    .err_float(err_float), .err_contend(err_contend), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  typedef struct {
    logic ld; logic [3:0] drv; logic [31:0] d; logic rdy; logic clr;
    logic v; logic [31:0] od; logic [2:0] cnt; logic fl; logic ct; logic ov;
  } vec_t;

  vec_t tbl[24];
  logic [31:0] q_d[$];
  logic [1:0]  q_s[$];
  logic m_fl, m_ct, m_ov;

  initial begin
    tbl[0]  = '{1, 4'b0010, 32'h33333333, 0, 0, 1, 32'h33333333, 1, 0, 0, 0};
    tbl[1]  = '{1, 4'b0001, 32'h1, 1, 0, 1, 32'h1, 1, 0, 0, 0};
    tbl[2]  = '{1, 4'b0100, 32'h2, 0, 0, 1, 32'h1, 2, 0, 0, 0};
    tbl[3]  = '{1, 4'b0100, 32'h3, 0, 0, 1, 32'h1, 3, 0, 0, 0};
    tbl[4]  = '{1, 4'b1000, 32'h4, 0, 0, 1, 32'h1, 4, 0, 0, 0};
    tbl[5]  = '{1, 4'b1000, 32'h5, 0, 0, 1, 32'h1, 4, 0, 0, 1};
    tbl[6]  = '{0, 4'b0000, 32'h0, 1, 0, 1, 32'h2, 3, 0, 0, 1};
    tbl[7]  = '{0, 4'b0000, 32'h0, 1, 0, 1, 32'h3, 2, 0, 0, 1};
    tbl[8]  = '{0, 4'b0000, 32'h0, 1, 0, 1, 32'h4, 1, 0, 0, 1};
    tbl[9]  = '{0, 4'b0000, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1};
    tbl[10] = '{1, 4'b0000, 32'h9, 1, 0, 0, 32'h0, 0, 1, 0, 1};
    tbl[11] = '{1, 4'b0110, 32'h9, 0, 0, 0, 32'h0, 0, 1, 1, 1};
    tbl[12] = '{0, 4'b0000, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0};
    tbl[13] = '{1, 4'b0000, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 0};
    tbl[14] = '{0, 4'b0000, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0};
    tbl[15] = '{1, 4'b0001, 32'h10, 0, 0, 1, 32'h10, 1, 0, 0, 0};
    tbl[16] = '{1, 4'b0010, 32'h20, 0, 0, 1, 32'h10, 2, 0, 0, 0};
    tbl[17] = '{1, 4'b0100, 32'h30, 0, 0, 1, 32'h10, 3, 0, 0, 0};
    tbl[18] = '{1, 4'b1000, 32'h40, 0, 0, 1, 32'h10, 4, 0, 0, 0};
    tbl[19] = '{1, 4'b0001, 32'hAA, 1, 0, 1, 32'h20, 4, 0, 0, 0};
    tbl[20] = '{0, 4'b0000, 32'h0, 1, 0, 1, 32'h30, 3, 0, 0, 0};
    tbl[21] = '{0, 4'b0000, 32'h0, 1, 0, 1, 32'h40, 2, 0, 0, 0};
    tbl[22] = '{0, 4'b0000, 32'h0, 1, 0, 1, 32'hAA, 1, 0, 0, 0};
    tbl[23] = '{0, 4'b0000, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 0};

    #1;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0); chk("rst_count", count, 0);
    chk("rst_errs", {err_float, err_contend, err_ovf}, 0);
    #2 rst = 0;

    for (int i = 0; i < 24; i++) begin
      ld = tbl[i].ld; drv_en = tbl[i].drv; bus_in = tbl[i].d; out_ready = tbl[i].rdy; clr_err = tbl[i].clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].v);
      chk($sformatf("v%0d_data", i), out_data, tbl[i].od);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_full", i), full, tbl[i].cnt == 4);
      chk($sformatf("v%0d_float", i), err_float, tbl[i].fl);
      chk($sformatf("v%0d_contend", i), err_contend, tbl[i].ct);
      chk($sformatf("v%0d_ovf", i), err_ovf, tbl[i].ov);
`ifdef BUS_RX_SRC_TAG_EN
      if (i == 0) chk("v0_src", out_src, 1);
`endif
    end

    // two entries stored, then reset pulsed between edges
    clr_err = 0; out_ready = 0; ld = 1;
    drv_en = 4'b0100; bus_in = 32'hC1; @(posedge clk); #1;
    bus_in = 32'hC2; @(posedge clk); #1;
    chk("pre_rst_count", count, 2);
    ld = 0;
    @(negedge clk); rst = 1; #1;
    chk("async_empty", empty, 1); chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0); chk("async_count", count, 0);
    #1 rst = 0; ld = 1; drv_en = 4'b1000; bus_in = 32'h77;
    @(posedge clk); #1;
    chk("first_edge_valid", out_valid, 1); chk("first_edge_data", out_data, 32'h77);
`ifdef BUS_RX_SRC_TAG_EN
    chk("first_edge_src", out_src, 3);
`endif
    q_d.push_back(32'h77); q_s.push_back(2'd3);
    m_fl = 0; m_ct = 0; m_ov = 0;

    for (int c = 0; c < 400; c++) begin
      int r, ones;
      logic pop;
      ld = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 7);
      drv_en = (r < 5) ? 4'(1 << $urandom_range(0, 3)) : (r == 5) ? 4'b0 : 4'($urandom);
      bus_in = $urandom;
      out_ready = $urandom_range(0, 1);
      clr_err = $urandom_range(0, 15) == 0;
      ones = $countones(drv_en);
      pop = out_ready && q_d.size() > 0;
      m_fl = (ld && ones == 0) || (m_fl && !clr_err);
      m_ct = (ld && ones > 1) || (m_ct && !clr_err);
      m_ov = (ld && ones == 1 && q_d.size() == 4 && !pop) || (m_ov && !clr_err);
      if (pop) begin void'(q_d.pop_front()); void'(q_s.pop_front()); end
      if (ld && ones == 1 && q_d.size() < 4) begin
        q_d.push_back(bus_in);
        q_s.push_back(drv_en[0] ? 2'd0 : drv_en[1] ? 2'd1 : drv_en[2] ? 2'd2 : 2'd3);
      end
      @(posedge clk); #1;
      chk("rnd_valid", out_valid, q_d.size() > 0);
      chk("rnd_data", out_data, q_d.size() > 0 ? q_d[0] : 32'h0);
      chk("rnd_count", count, q_d.size());
      chk("rnd_full", full, q_d.size() == 4);
      chk("rnd_empty", empty, q_d.size() == 0);
      chk("rnd_errs", {err_float, err_contend, err_ovf}, {m_fl, m_ct, m_ov});
`ifdef BUS_RX_SRC_TAG_EN
      chk("rnd_src", out_src, q_s.size() > 0 ? q_s[0] : 2'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_rx.md
BUS_RX -- requirements
Module: bus_rx

Interface
REQ-001 Parameter WIDTH, default 32: bus data width in bits.
REQ-002 Parameter NDRV, default 4: number of tri-state drivers on the shared bus.
REQ-003 Parameter DEPTH, default 4, power of two: receive FIFO entries.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 bus_in  input  WIDTH  shared tri-state data bus.
REQ-007 drv_en  input  NDRV  copy of each driver's tri-state state (enable) line.
REQ-008 ld  input  1  load strobe: capture bus_in this cycle.
REQ-009 clr_err  input  1  clears all sticky error flags.
REQ-010 out_data  output  WIDTH  FIFO head data (show-ahead).
REQ-011 out_valid  output  1  out_data holds a valid entry.
REQ-012 out_ready  input  1  consumer accepts the head entry.
REQ-013 full, empty  output  1 each  FIFO occupancy flags.
REQ-014 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 err_float, err_contend, err_ovf  output  1 each  sticky flags: no driver, multiple drivers, overflow.

Function
REQ-016 Capture is legal only when ld=1 and drv_en is exactly one-hot; bus_in is sampled on that rising edge.
REQ-017 ld=1 with drv_en=0: no capture; err_float set on the next edge.
REQ-018 ld=1 with two or more drv_en bits set: no capture; err_contend set on the next edge.
REQ-019 A pop occurs on an edge where out_valid=1 and out_ready=1.
REQ-020 Latency: an entry captured at edge N into an empty FIFO drives out_valid=1 and out_data after edge N, with no combinational path from bus_in to out_data.
REQ-021 Legal capture while full with no pop in the same cycle: data dropped, contents unchanged, err_ovf set.
REQ-022 Legal capture while full with a simultaneous pop: both occur; count stays DEPTH.
REQ-023 Simultaneous push and pop at any other occupancy: count unchanged; order preserved.
REQ-024 A pop when empty cannot occur, because out_valid=0.
REQ-025 Read and write pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-026 Error flags are sticky until clr_err=1.
REQ-027 clr_err and a new error event on the same edge: the flag stays set (set wins).
REQ-028 FIFO ordering is strictly first-in first-out.

Reset
REQ-029 rst=1 immediately forces: pointers 0, count 0, empty=1, full=0, out_valid=0, all error flags 0.
REQ-030 rst=1 forces out_data to all-zero.
REQ-031 Reset asserted mid-transfer discards all stored entries; no capture or pop completes while rst=1.
REQ-032 The first capture after rst deasserts can occur on the first rising edge.

Configuration
REQ-033 With BUS_RX_SRC_TAG_EN defined:
- each entry also stores the clog2(NDRV)-bit index of the active driver;
- the index is presented on output out_src, aligned with out_data;
- out_src resets to 0.
REQ-034 Without BUS_RX_SRC_TAG_EN, the out_src port and tag storage do not exist; all other behaviour is identical.

Structure
REQ-035 Shared package bus_pkg holds:
- default WIDTH, NDRV and DEPTH constants;
- a one-hot check function;
- a one-hot-to-index encode function.
REQ-036 Storage and pointers sit in sub-module bus_rx_fifo. Driver check, capture decision and error flags sit in bus_rx.

Verification
REQ-037 Reset, then ld=1, drv_en=4'b0010, bus_in=32'h33333333 -> next cycle out_valid=1, out_data=32'h33333333, count=1; with the macro defined, out_src=1.
REQ-038 Five legal captures 32'h1..32'h5 with out_ready=0 -> full=1 after the 4th, err_ovf=1 after the 5th; popping then yields 1,2,3,4.
REQ-039 ld=1 with drv_en=0 -> err_float=1, count unchanged; ld=1 with drv_en=4'b0110 -> err_contend=1; clr_err=1 -> both flags 0.
REQ-040 FIFO full, out_ready=1, legal capture of 32'hAA -> count stays 4; 32'hAA emerges after the three older entries.
REQ-041 Two entries stored, rst pulsed between clock edges -> empty=1, out_valid=0, out_data=0 immediately, without waiting for a clock edge.
